// File: rtl/pcie_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// pcie_tx_arb_pkg
//   Shared types and constants for the PCIe TRN transmit arbiter.
//   - arb_state_e : arbiter FSM states
//   - grant_e     : encoding driven on arb_grant_o
//   - TBUF_*      : bit positions inside trn_tbuf_av
// -----------------------------------------------------------------------------
package pcie_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPL  = 2'b01,
    ST_DMA  = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_CPL  = 2'b01,
    GRANT_DMA  = 2'b10
  } grant_e;

  // trn_tbuf_av bit positions: posted-request and completion buffer space.
  localparam int TBUF_POSTED = 1;
  localparam int TBUF_CPL    = 2;

  // Width of the DMA starvation counter.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/pcie_tx_arbiter.sv
// -----------------------------------------------------------------------------
// pcie_tx_arbiter
//   Shares the 64-bit TRN transmit interface of the PCIe endpoint core between
//   the completion engine (cpl_*) and the DMA write engine (dma_*). Whole
//   packets are granted; a grant needs buffer space in the core for that TLP
//   type. Completions win by default, but after MAX_WAIT consecutive completion
//   grants with DMA waiting, DMA is forced through.
//
// Ports
//   trn_clk, trn_reset_n       clock, asynchronous active-low reset
//   trn_lnk_up_n               link up (active-low); no grants while down
//   cpl_* / dma_* (inputs)     requester TLP stream (td, trem_n, sof, eof, rdy)
//   cpl_/dma_tdst_rdy_n_o      ready back to each requester
//   cpl_/dma_tdsc_n_o          one-cycle abort pulse to the owning requester
//   trn_t* (outputs)           core TX stream, muxed from the owner
//   trn_tdst_rdy_n/_dsc_n      core ready and core discontinue
//   trn_tbuf_av                core buffer availability ([1] posted, [2] cpl)
//   arb_grant_o                current owner: 00 none, 01 cpl, 10 dma
// -----------------------------------------------------------------------------
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REM_WIDTH  = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  trn_clk,
  input  logic                  trn_reset_n,
  input  logic                  trn_lnk_up_n,

  input  logic [DATA_WIDTH-1:0] cpl_td_i,
  input  logic [REM_WIDTH-1:0]  cpl_trem_n_i,
  input  logic                  cpl_tsof_n_i,
  input  logic                  cpl_teof_n_i,
  input  logic                  cpl_tsrc_rdy_n_i,
  output logic                  cpl_tdst_rdy_n_o,
  output logic                  cpl_tdsc_n_o,

  input  logic [DATA_WIDTH-1:0] dma_td_i,
  input  logic [REM_WIDTH-1:0]  dma_trem_n_i,
  input  logic                  dma_tsof_n_i,
  input  logic                  dma_teof_n_i,
  input  logic                  dma_tsrc_rdy_n_i,
  output logic                  dma_tdst_rdy_n_o,
  output logic                  dma_tdsc_n_o,

  output logic [DATA_WIDTH-1:0] trn_td,
  output logic [REM_WIDTH-1:0]  trn_trem_n,
  output logic                  trn_tsof_n,
  output logic                  trn_teof_n,
  output logic                  trn_tsrc_rdy_n,
  output logic                  trn_tsrc_dsc_n,
  input  logic                  trn_tdst_rdy_n,
  input  logic                  trn_tdst_dsc_n,
  input  logic [3:0]            trn_tbuf_av,

  output logic [1:0]            arb_grant_o
);

  arb_state_e          state_q;
  grant_e              grant_q;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;

  logic link_up;
  logic cpl_pend, dma_pend;
  logic cpl_elig, dma_elig;
  logic starved;
  logic pick_cpl, pick_dma;
  logic own_cpl, own_dma;
  logic dsc_hit;
  logic eof_acc;

  // Only the posted and completion bits of trn_tbuf_av matter here.
  logic unused_tbuf;
  assign unused_tbuf = trn_tbuf_av[0] ^ trn_tbuf_av[3];

  assign link_up  = ~trn_lnk_up_n;
  assign cpl_pend = ~cpl_tsrc_rdy_n_i & ~cpl_tsof_n_i;
  assign dma_pend = ~dma_tsrc_rdy_n_i & ~dma_tsof_n_i;
  assign cpl_elig = cpl_pend & trn_tbuf_av[TBUF_CPL];
  assign dma_elig = dma_pend & trn_tbuf_av[TBUF_POSTED];
  assign starved  = (starve_cnt_q == STARVE_W'(MAX_WAIT));

  // DMA wins when it has waited long enough, or when cpl cannot go anyway.
  assign pick_dma = dma_elig & (starved | ~cpl_elig);
  assign pick_cpl = cpl_elig & ~pick_dma;

  assign own_cpl = (state_q == ST_CPL);
  assign own_dma = (state_q == ST_DMA);

  // A discontinue during a link drop is swallowed: the link drop alone
  // returns the FSM to idle and no abort pulse is sent.
  assign dsc_hit = ~trn_tdst_dsc_n & link_up;

  // ---------------------------------------------------------------------------
  // Data path: zero-latency mux from the owner to the core.
  // ---------------------------------------------------------------------------
  always_comb begin
    trn_td         = '0;
    trn_trem_n     = '1;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    case (state_q)
      ST_CPL: begin
        trn_td         = cpl_td_i;
        trn_trem_n     = cpl_trem_n_i;
        trn_tsof_n     = cpl_tsof_n_i;
        trn_teof_n     = cpl_teof_n_i;
        trn_tsrc_rdy_n = cpl_tsrc_rdy_n_i;
      end
      ST_DMA: begin
        trn_td         = dma_td_i;
        trn_trem_n     = dma_trem_n_i;
        trn_tsof_n     = dma_tsof_n_i;
        trn_teof_n     = dma_teof_n_i;
        trn_tsrc_rdy_n = dma_tsrc_rdy_n_i;
      end
      default: ;
    endcase
  end

  // The arbiter itself never aborts a packet.
  assign trn_tsrc_dsc_n = 1'b1;

  // Ready is withheld from the owner in the discontinue cycle so the
  // requester does not count that beat as delivered.
  assign cpl_tdst_rdy_n_o = ~(own_cpl & ~trn_tdst_rdy_n & ~dsc_hit);
  assign dma_tdst_rdy_n_o = ~(own_dma & ~trn_tdst_rdy_n & ~dsc_hit);
  assign cpl_tdsc_n_o     = ~(own_cpl & dsc_hit);
  assign dma_tdsc_n_o     = ~(own_dma & dsc_hit);

  assign eof_acc = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n & ~trn_teof_n;

  // ---------------------------------------------------------------------------
  // Starvation counter next state. Only arbitration decisions in idle move
  // it; a discontinue leaves it alone, a link drop clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!link_up) begin
      starve_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (pick_dma) begin
        starve_cnt_d = '0;
      end else if (pick_cpl && dma_pend && (starve_cnt_q < STARVE_W'(MAX_WAIT))) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration FSM with registered grant output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_NONE;
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (link_up && pick_dma) begin
            state_q <= ST_DMA;
            grant_q <= GRANT_DMA;
          end else if (link_up && pick_cpl) begin
            state_q <= ST_CPL;
            grant_q <= GRANT_CPL;
          end
        end
        ST_CPL, ST_DMA: begin
          // Discontinue and EOF both end ownership; the pulse itself is
          // combinational, so a coincident EOF cannot suppress it.
          if (!link_up || dsc_hit || eof_acc) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  assign arb_grant_o = grant_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pcie_tx_arbiter
//   Self-checking bench for pcie_tx_arbiter. Requesters are modelled as packet
//   queues; delivered beats are scored per source in order, and the packet
//   grant order is predicted from the priority/starvation rule at packet level.
// -----------------------------------------------------------------------------
module tb_pcie_tx_arbiter;

  localparam int MAXW = 4;

  logic        trn_clk = 1'b0;
  logic        trn_reset_n;
  logic        trn_lnk_up_n;
  logic [63:0] cpl_td_i, dma_td_i;
  logic [7:0]  cpl_trem_n_i, dma_trem_n_i;
  logic        cpl_tsof_n_i, cpl_teof_n_i, cpl_tsrc_rdy_n_i;
  logic        dma_tsof_n_i, dma_teof_n_i, dma_tsrc_rdy_n_i;
  logic        cpl_tdst_rdy_n_o, cpl_tdsc_n_o, dma_tdst_rdy_n_o, dma_tdsc_n_o;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n, trn_tdst_dsc_n;
  logic [3:0]  trn_tbuf_av;
  logic [1:0]  arb_grant_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  rem;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t      cpl_q[$], dma_q[$];      // beats still to be presented
  beat_t      cpl_exp[$], dma_exp[$];  // beats still to be seen at the core
  logic [1:0] grant_log[$];
  logic [1:0] exp_order[$];

  pcie_tx_arbiter #(.DATA_WIDTH(64), .REM_WIDTH(8), .MAX_WAIT(MAXW)) dut (
    .trn_clk          (trn_clk),
    .trn_reset_n      (trn_reset_n),
    .trn_lnk_up_n     (trn_lnk_up_n),
    .cpl_td_i         (cpl_td_i),
    .cpl_trem_n_i     (cpl_trem_n_i),
    .cpl_tsof_n_i     (cpl_tsof_n_i),
    .cpl_teof_n_i     (cpl_teof_n_i),
    .cpl_tsrc_rdy_n_i (cpl_tsrc_rdy_n_i),
    .cpl_tdst_rdy_n_o (cpl_tdst_rdy_n_o),
    .cpl_tdsc_n_o     (cpl_tdsc_n_o),
    .dma_td_i         (dma_td_i),
    .dma_trem_n_i     (dma_trem_n_i),
    .dma_tsof_n_i     (dma_tsof_n_i),
    .dma_teof_n_i     (dma_teof_n_i),
    .dma_tsrc_rdy_n_i (dma_tsrc_rdy_n_i),
    .dma_tdst_rdy_n_o (dma_tdst_rdy_n_o),
    .dma_tdsc_n_o     (dma_tdsc_n_o),
    .trn_td           (trn_td),
    .trn_trem_n       (trn_trem_n),
    .trn_tsof_n       (trn_tsof_n),
    .trn_teof_n       (trn_teof_n),
    .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n   (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n   (trn_tdst_rdy_n),
    .trn_tdst_dsc_n   (trn_tdst_dsc_n),
    .trn_tbuf_av      (trn_tbuf_av),
    .arb_grant_o      (arb_grant_o)
  );

  always #5 trn_clk = ~trn_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic add_pkt(input bit to_dma, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = {$urandom, $urandom};
      b.sof = (i == 0);
      b.eof = (i == len - 1);
      b.rem = b.eof ? 8'($urandom) : 8'h00;
      if (to_dma) begin
        dma_q.push_back(b);
        dma_exp.push_back(b);
      end else begin
        cpl_q.push_back(b);
        cpl_exp.push_back(b);
      end
    end
  endtask

  task automatic drive_src();
    if (cpl_q.size() > 0) begin
      cpl_td_i = cpl_q[0].d; cpl_trem_n_i = cpl_q[0].rem;
      cpl_tsof_n_i = !cpl_q[0].sof; cpl_teof_n_i = !cpl_q[0].eof; cpl_tsrc_rdy_n_i = 1'b0;
    end else begin
      cpl_td_i = '0; cpl_trem_n_i = '0;
      cpl_tsof_n_i = 1'b1; cpl_teof_n_i = 1'b1; cpl_tsrc_rdy_n_i = 1'b1;
    end
    if (dma_q.size() > 0) begin
      dma_td_i = dma_q[0].d; dma_trem_n_i = dma_q[0].rem;
      dma_tsof_n_i = !dma_q[0].sof; dma_teof_n_i = !dma_q[0].eof; dma_tsrc_rdy_n_i = 1'b0;
    end else begin
      dma_td_i = '0; dma_trem_n_i = '0;
      dma_tsof_n_i = 1'b1; dma_teof_n_i = 1'b1; dma_tsrc_rdy_n_i = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"},    64'(arb_grant_o),      64'(2'b00));
    chk({tag, "_srcrdy"},   64'(trn_tsrc_rdy_n),   64'(1'b1));
    chk({tag, "_sof"},      64'(trn_tsof_n),       64'(1'b1));
    chk({tag, "_eof"},      64'(trn_teof_n),       64'(1'b1));
    chk({tag, "_srcdsc"},   64'(trn_tsrc_dsc_n),   64'(1'b1));
    chk({tag, "_td"},       trn_td,                64'h0);
    chk({tag, "_trem"},     64'(trn_trem_n),       64'hFF);
    chk({tag, "_cpl_rdy"},  64'(cpl_tdst_rdy_n_o), 64'(1'b1));
    chk({tag, "_dma_rdy"},  64'(dma_tdst_rdy_n_o), 64'(1'b1));
    chk({tag, "_cpl_dsc"},  64'(cpl_tdsc_n_o),     64'(1'b1));
    chk({tag, "_dma_dsc"},  64'(dma_tdsc_n_o),     64'(1'b1));
    chk({tag, "_starve"},   64'(dut.starve_cnt_q), 64'h0);
  endtask

  // Cycle loop: sources present queued beats, the core side is scored.
  task automatic run_traffic(input int budget, input bit rnd_rdy);
    int    cyc = 0;
    int    avail;
    bit    cpl_adv, dma_adv;
    beat_t e;
    while ((cpl_exp.size() > 0 || dma_exp.size() > 0) && cyc < budget) begin
      drive_src();
      trn_tdst_rdy_n = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      #4;
      if (arb_grant_o == 2'b01) begin
        chk("nonowner_rdy_dma", 64'(dma_tdst_rdy_n_o), 64'(1'b1));
        chk("owner_rdy_cpl",    64'(cpl_tdst_rdy_n_o), 64'(trn_tdst_rdy_n));
      end else if (arb_grant_o == 2'b10) begin
        chk("nonowner_rdy_cpl", 64'(cpl_tdst_rdy_n_o), 64'(1'b1));
        chk("owner_rdy_dma",    64'(dma_tdst_rdy_n_o), 64'(trn_tdst_rdy_n));
      end else begin
        chk("idle_core_srcrdy", 64'(trn_tsrc_rdy_n), 64'(1'b1));
      end
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        avail = (arb_grant_o == 2'b01) ? cpl_exp.size() :
                (arb_grant_o == 2'b10) ? dma_exp.size() : 0;
        chk("beat_expected", 64'(avail > 0), 64'(1'b1));
        if (avail > 0) begin
          if (arb_grant_o == 2'b01) e = cpl_exp.pop_front();
          else                      e = dma_exp.pop_front();
          chk("beat_td",   trn_td,            e.d);
          chk("beat_trem", 64'(trn_trem_n),   64'(e.rem));
          chk("beat_sof",  64'(trn_tsof_n),   64'(!e.sof));
          chk("beat_eof",  64'(trn_teof_n),   64'(!e.eof));
        end
        if (!trn_tsof_n) grant_log.push_back(arb_grant_o);
      end
      cpl_adv = !cpl_tsrc_rdy_n_i && !cpl_tdst_rdy_n_o;
      dma_adv = !dma_tsrc_rdy_n_i && !dma_tdst_rdy_n_o;
      step();
      if (cpl_adv && cpl_q.size() > 0) cpl_q.delete(0);
      if (dma_adv && dma_q.size() > 0) dma_q.delete(0);
      cyc++;
    end
    chk("traffic_budget", 64'(cyc < budget), 64'(1'b1));
    drive_src();
    trn_tdst_rdy_n = 1'b0;
  endtask

  initial begin
    int c, d, w;
    logic [63:0] d0, d1, c0;

    // ---------------- reset ----------------
    trn_reset_n    = 1'b0;
    trn_lnk_up_n   = 1'b1;
    trn_tdst_rdy_n = 1'b1;
    trn_tdst_dsc_n = 1'b1;
    trn_tbuf_av    = 4'b0000;
    drive_src();
    #12;
    chk_reset_vals("reset");
    step();
    trn_reset_n    = 1'b1;
    trn_lnk_up_n   = 1'b0;
    trn_tbuf_av    = 4'b0110;
    trn_tdst_rdy_n = 1'b0;
    step();
    step();

    // ---------------- single 3-beat cpl packet ----------------
    add_pkt(1'b0, 3);
    drive_src();
    #4;
    chk("t1_pre_grant",  64'(arb_grant_o),    64'(2'b00));
    chk("t1_pre_srcrdy", 64'(trn_tsrc_rdy_n), 64'(1'b1));
    step();
    trn_tdst_rdy_n = 1'b1;
    drive_src();
    #4;
    chk("t1_grant", 64'(arb_grant_o), 64'(2'b01));
    chk("t1_sof",   64'(trn_tsof_n),  64'(1'b0));
    chk("t1_td",    trn_td,           cpl_q[0].d);
    step();
    run_traffic(50, 1'b0);
    #4;
    chk("t1_post_grant", 64'(arb_grant_o), 64'(2'b00));
    step();

    // ---------------- cpl with random core ready ----------------
    grant_log.delete();
    for (int i = 0; i < 3; i++) add_pkt(1'b0, int'($urandom_range(1, 5)));
    run_traffic(500, 1'b1);
    chk("t2_pkt_count", 64'(grant_log.size()), 64'd3);
    foreach (grant_log[i]) chk("t2_grant_cpl", 64'(grant_log[i]), 64'(2'b01));
    step();

    // ---------------- contention / starvation guard ----------------
    grant_log.delete();
    exp_order.delete();
    for (int i = 0; i < 10; i++) add_pkt(1'b0, int'($urandom_range(1, 3)));
    for (int i = 0; i < 3; i++)  add_pkt(1'b1, int'($urandom_range(1, 3)));
    c = 10; d = 3; w = 0;
    while (c > 0 || d > 0) begin
      if (d > 0 && (w == MAXW || c == 0)) begin
        exp_order.push_back(2'b10); d--; w = 0;
      end else begin
        exp_order.push_back(2'b01); c--;
        if (d > 0 && w < MAXW) w++;
      end
    end
    run_traffic(3000, 1'b1);
    chk("t3_pkt_count", 64'(grant_log.size()), 64'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      chk("t3_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
    step();

    // ---------------- dma gated by posted buffer ----------------
    trn_tbuf_av = 4'b0100;
    add_pkt(1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      drive_src();
      #4;
      chk("t4_gated_grant",  64'(arb_grant_o),    64'(2'b00));
      chk("t4_gated_srcrdy", 64'(trn_tsrc_rdy_n), 64'(1'b1));
      step();
    end
    trn_tbuf_av = 4'b0110;
    drive_src();
    #4;
    chk("t4_open_grant", 64'(arb_grant_o), 64'(2'b00));
    step();
    trn_tdst_rdy_n = 1'b1;
    drive_src();
    #4;
    chk("t4_dma_grant", 64'(arb_grant_o), 64'(2'b10));
    chk("t4_dma_sof",   64'(trn_tsof_n),  64'(1'b0));
    chk("t4_dma_td",    trn_td,           dma_q[0].d);
    step();
    run_traffic(50, 1'b0);
    step();

    // ---------------- core discontinue on dma beat 2 ----------------
    trn_tdst_dsc_n = 1'b0;
    #4;
    chk("t5_idle_dsc_cpl",   64'(cpl_tdsc_n_o), 64'(1'b1));
    chk("t5_idle_dsc_dma",   64'(dma_tdsc_n_o), 64'(1'b1));
    step();
    trn_tdst_dsc_n = 1'b1;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    c0 = {$urandom, $urandom};
    dma_td_i = d0; dma_trem_n_i = 8'h00;
    dma_tsof_n_i = 1'b0; dma_teof_n_i = 1'b1; dma_tsrc_rdy_n_i = 1'b0;
    #4;
    chk("t5_pre_grant", 64'(arb_grant_o), 64'(2'b00));
    step();
    cpl_td_i = c0; cpl_trem_n_i = 8'h0F;
    cpl_tsof_n_i = 1'b0; cpl_teof_n_i = 1'b0; cpl_tsrc_rdy_n_i = 1'b0;
    #4;
    chk("t5_dma_grant",     64'(arb_grant_o),      64'(2'b10));
    chk("t5_dma_td0",       trn_td,                d0);
    chk("t5_cpl_rdy_block", 64'(cpl_tdst_rdy_n_o), 64'(1'b1));
    step();
    dma_td_i = d1; dma_tsof_n_i = 1'b1;
    trn_tdst_dsc_n = 1'b0;
    #4;
    chk("t5_dsc_pulse",   64'(dma_tdsc_n_o),     64'(1'b0));
    chk("t5_dsc_rdy",     64'(dma_tdst_rdy_n_o), 64'(1'b1));
    chk("t5_dsc_cpl",     64'(cpl_tdsc_n_o),     64'(1'b1));
    chk("t5_dma_td1",     trn_td,                d1);
    step();
    trn_tdst_dsc_n = 1'b1;
    dma_tsrc_rdy_n_i = 1'b1; dma_tsof_n_i = 1'b1;
    #4;
    chk("t5_pulse_end",   64'(dma_tdsc_n_o),   64'(1'b1));
    chk("t5_after_grant", 64'(arb_grant_o),    64'(2'b00));
    step();
    #4;
    chk("t5_cpl_grant",   64'(arb_grant_o),    64'(2'b01));
    chk("t5_cpl_td",      trn_td,              c0);
    chk("t5_cpl_eof",     64'(trn_teof_n),     64'(1'b0));
    step();
    cpl_tsrc_rdy_n_i = 1'b1; cpl_tsof_n_i = 1'b1; cpl_teof_n_i = 1'b1;
    #4;
    chk("t5_end_grant",   64'(arb_grant_o),    64'(2'b00));
    step();

    // ---------------- link drop mid-packet ----------------
    trn_tbuf_av = 4'b0100;   // dma pending but never eligible
    dma_td_i = {$urandom, $urandom};
    dma_tsof_n_i = 1'b0; dma_teof_n_i = 1'b1; dma_tsrc_rdy_n_i = 1'b0;
    cpl_td_i = {$urandom, $urandom};
    cpl_tsof_n_i = 1'b0; cpl_teof_n_i = 1'b1; cpl_tsrc_rdy_n_i = 1'b0;
    step();
    #4;
    chk("t6_grant",      64'(arb_grant_o),      64'(2'b01));
    chk("t6_starve_inc", 64'(dut.starve_cnt_q), 64'd1);
    step();
    cpl_tsof_n_i = 1'b1;
    cpl_td_i = {$urandom, $urandom};
    trn_lnk_up_n = 1'b1;
    #4;
    chk("t6_no_pulse",   64'(cpl_tdsc_n_o),     64'(1'b1));
    step();
    #4;
    chk_reset_vals("t6_linkdown");
    step();
    cpl_tsof_n_i = 1'b0;
    #4;
    chk("t6_no_grant_down", 64'(arb_grant_o),   64'(2'b00));
    step();
    trn_lnk_up_n = 1'b0;
    cpl_tsrc_rdy_n_i = 1'b1; cpl_tsof_n_i = 1'b1;
    step();

    // ---------------- asynchronous reset mid-packet ----------------
    cpl_td_i = {$urandom, $urandom};
    cpl_tsof_n_i = 1'b0; cpl_teof_n_i = 1'b1; cpl_tsrc_rdy_n_i = 1'b0;
    step();
    #4;
    chk("t7_grant",      64'(arb_grant_o),      64'(2'b01));
    chk("t7_starve_inc", 64'(dut.starve_cnt_q), 64'd1);
    step();
    cpl_tsof_n_i = 1'b1;
    #2;
    trn_reset_n = 1'b0;
    #1;
    chk_reset_vals("t7_async");
    step();
    cpl_tsrc_rdy_n_i = 1'b1;
    dma_tsrc_rdy_n_i = 1'b1; dma_tsof_n_i = 1'b1;
    trn_tbuf_av = 4'b0110;
    step();
    trn_reset_n = 1'b1;
    step();
    #4;
    chk("t7_post_grant", 64'(arb_grant_o), 64'(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-boundary arbiter that shares the single 64-bit TRN transmit interface of the PCIe endpoint core between two TLP sources: the completion engine (PIO read completions) and the DMA write engine (FOFB memory-write TLPs).
- Sits between those engines and the core's `trn_t*` ports.
- Grants whole packets and gates each grant on the core's per-type buffer availability.
- Completions have priority, with a starvation guard for DMA.
- Handles core-initiated discontinue.

## Interface
Parameters:
- `DATA_WIDTH`, 64, TLP data width.
- `REM_WIDTH`, 8, remainder width, active-low per byte.
- `MAX_WAIT`, 4, consecutive completion grants allowed while DMA is pending before DMA is forced to win; range 1..15.

Ports:
- `trn_clk`  in  1  core transaction clock; the only clock.
- `trn_reset_n`  in  1  asynchronous, active-low reset.
- `trn_lnk_up_n`  in  1  link up, active-low.
- `cpl_td_i` / `dma_td_i`  in  64  requester TLP data.
- `cpl_trem_n_i` / `dma_trem_n_i`  in  8  requester remainder.
- `cpl_tsof_n_i`, `cpl_teof_n_i`, `cpl_tsrc_rdy_n_i` (and `dma_*` equivalents)  in  1 each  requester framing and valid.
- `cpl_tdst_rdy_n_o` / `dma_tdst_rdy_n_o`  out  1  ready back to requester.
- `cpl_tdsc_n_o` / `dma_tdsc_n_o`  out  1  one-cycle abort pulse to requester.
- `trn_td`  out  64  core TX data.
- `trn_trem_n`  out  8  core TX remainder.
- `trn_tsof_n`, `trn_teof_n`, `trn_tsrc_rdy_n`, `trn_tsrc_dsc_n`  out  1 each  core TX framing.
- `trn_tdst_rdy_n`, `trn_tdst_dsc_n`  in  1 each  core TX ready and discontinue.
- `trn_tbuf_av`  in  4  core buffer availability: [1] posted, [2] completion.
- `arb_grant_o`  out  2  current owner: 00 none, 01 cpl, 10 dma.

## Operation
- FSM states:
  - `ST_IDLE`: no owner.
  - `ST_CPL`: completion engine owns the link.
  - `ST_DMA`: DMA engine owns the link.
- A requester is pending when both `tsrc_rdy_n=0` and `tsof_n=0`.
- Eligibility:
  - cpl is eligible when it is pending and `trn_tbuf_av[2]=1`.
  - dma is eligible when it is pending and `trn_tbuf_av[1]=1`.
- Choice in `ST_IDLE` when `trn_lnk_up_n=0`:
  - If `starve_cnt==MAX_WAIT` and dma is eligible, dma wins.
  - Otherwise cpl wins if eligible.
  - Otherwise dma wins if eligible.
  - Otherwise the FSM stays in `ST_IDLE`.
- `starve_cnt` (4-bit):
  - Increments on each cpl grant while dma is pending, saturating at `MAX_WAIT`.
  - Clears on each dma grant.
- While granted:
  - Core outputs are a combinational mux of the owner's inputs.
  - Owner's `tdst_rdy_n` equals `trn_tdst_rdy_n`.
  - Non-owner's `tdst_rdy_n` is 1.
- Beat accepted = `trn_tsrc_rdy_n=0` and `trn_tdst_rdy_n=0`. An accepted beat with `teof_n=0` returns the FSM to `ST_IDLE`.
- Ungranted: `trn_tsrc_rdy_n`, `trn_tsof_n`, `trn_teof_n` and `trn_tsrc_dsc_n` are 1; `trn_td` is 0; `trn_trem_n` is 0xFF.
- `trn_tsrc_dsc_n` stays at 1. The arbiter never aborts a packet itself.
- Core discontinue (`trn_tdst_dsc_n=0` in `ST_CPL`/`ST_DMA`):
  - Owner's `tdsc_n_o` is 0 for exactly one cycle.
  - Owner's `tdst_rdy_n` is forced to 1 that cycle.
  - FSM returns to `ST_IDLE`.
  - `starve_cnt` is unchanged.
- `trn_tdst_dsc_n=0` in `ST_IDLE` is ignored.
- Link drop (`trn_lnk_up_n=1`):
  - Forces `ST_IDLE` next cycle with no discontinue pulse.
  - Clears `starve_cnt`.
  - No grants are issued until the link is up again.
- Simultaneous EOF acceptance and `trn_tdst_dsc_n=0`: discontinue wins, so the pulse is issued.

## Timing
- Reset values:
  - FSM `ST_IDLE`, `starve_cnt=0`, `arb_grant_o=00`.
  - All `*_n` outputs 1, except `trn_trem_n=0xFF`.
  - `trn_td=0`.
- Arbitration latency: 1 cycle. A pending SOF at cycle N is first presented to the core at N+1.
- Data path: zero added latency, no buffering. Throughput is one beat per cycle while the owner is valid and the core is ready.
- Back-to-back: after an EOF accepted at cycle N, the next packet's SOF is presented at N+2 at the earliest, because cycle N+1 is `ST_IDLE`.
- `trn_tbuf_av` is sampled only in `ST_IDLE`. A mid-packet deassertion does not affect the packet in flight.
- Asynchronous reset mid-packet: outputs return to reset values immediately, with no EOF generated.

## Structure
- Package `pcie_tx_arb_pkg` holds:
  - The state enum.
  - The grant encoding.
  - `TBUF_POSTED=1` and `TBUF_CPL=2`.
- The block is a single module, with no sub-module. The mux, FSM and starvation counter are inline.

## Test plan
- Both requesters idle, then a 3-beat cpl packet with `tbuf_av=0110` -> SOF on `trn_t*` one cycle later, 3 beats passed through unchanged, `arb_grant_o` 01 then 00.
- cpl and dma both pending continuously, `MAX_WAIT=4` -> grant sequence cpl, cpl, cpl, cpl, dma, repeating.
- dma pending with `tbuf_av[1]=0`, cpl idle -> no grant. Set `tbuf_av[1]=1` -> dma SOF appears 1 cycle later.
- Core drives `trn_tdst_dsc_n=0` on beat 2 of a 4-beat dma packet -> `dma_tdsc_n_o` is low for 1 cycle, FSM goes idle, and a pending cpl is granted next.
- `trn_tdst_rdy_n` toggled randomly during a cpl packet -> every beat is delivered exactly once and in order; the non-owner's `tdst_rdy_n` stays at 1.
- Link drops mid-packet, then asynchronous reset is asserted mid-packet -> both cases give idle, all outputs at reset values, `starve_cnt=0`.
